// File: rtl/fib_pkg.sv
// Types and widths shared between the Fibonacci stage and its result collector.
// A collector entry is a result tagged with the request index that produced it.
package fib_pkg;

   localparam int FIB_N_W    = 4;
   localparam int FIB_DATA_W = 32;

   typedef struct packed {
      logic [FIB_N_W-1:0]    n;
      logic [FIB_DATA_W-1:0] data;
   } fib_entry_t;

   function automatic fib_entry_t make_entry(input logic [FIB_N_W-1:0]    n_v,
                                             input logic [FIB_DATA_W-1:0] data_v);
      fib_entry_t e;
      e.n    = n_v;
      e.data = data_v;
      return e;
   endfunction

endpackage

// File: rtl/fib_sync_fifo.sv
// Generic show-ahead synchronous FIFO with register-array storage.
// Pointers carry one extra MSB so matching addresses can be told apart as full or empty.
module fib_sync_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level_o = LW'(wr_ptr_q - rd_ptr_q);
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts then.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/fib_result_collector.sv
// Captures every Fibonacci stage result once, tags it with its request index and
// queues it for a valid/ready consumer; results arriving while the queue is full are counted.
module fib_result_collector
   import fib_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = FIB_DATA_W,
   parameter int N_W    = FIB_N_W,
   parameter int CNT_W  = 16
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       start,
   input  logic [N_W-1:0]             n,
   input  logic [DATA_W-1:0]          data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [N_W-1:0]             out_n,
   output logic [DATA_W-1:0]          out_data,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       full,
   output logic                       overflow,
   output logic [CNT_W-1:0]           drop_cnt,
   input  logic                       clr_ovf
);

   localparam int ENTRY_W = N_W + DATA_W;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic               cap_vld_q;
   logic [N_W-1:0]     cap_n_q;
   logic               overflow_q, overflow_d;
   logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
   logic [ENTRY_W-1:0] head;
   logic               fifo_empty, fifo_full, pop, drop;

   // The stage's data register updates on the edge that samples start, so the result
   // for a request is on data during the cycle after start, while cap_vld_q is high.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cap_vld_q <= 1'b0;
         cap_n_q   <= '0;
      end else begin
         cap_vld_q <= start;
         cap_n_q   <= n;
      end
   end

   fib_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push_i  (cap_vld_q),
      .wdata_i ({cap_n_q, data}),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (level)
   );

   // Handshake: out_valid stays high with a stable head until the consumer takes it;
   // an entry leaves on any rising edge where out_valid && out_ready.
   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   assign out_n     = head[DATA_W +: N_W];
   assign out_data  = head[DATA_W-1:0];
   assign full      = fifo_full;
   assign drop      = cap_vld_q && fifo_full && !pop;

   always_comb begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      if (clr_ovf) begin
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end else if (drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign overflow = overflow_q;
   assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_fib_result_collector.sv
// Directed bench for fib_result_collector: a queue model of the collector checked
// every cycle, plus literal expectations at the points the scenarios call out.
module tb_fib_result_collector;

   localparam int DEPTH  = 8;
   localparam int DATA_W = 32;
   localparam int N_W    = 4;
   localparam int CNT_W  = 16;
   localparam int LVL_W  = $clog2(DEPTH+1);
   localparam int E_W    = N_W + DATA_W;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              resetn = 1'b0;
   logic              start = 1'b0;
   logic [N_W-1:0]    n = '0;
   logic [DATA_W-1:0] data = '0;
   logic              out_ready = 1'b0;
   logic              clr_ovf = 1'b0;
   logic              out_valid;
   logic [N_W-1:0]    out_n;
   logic [DATA_W-1:0] out_data;
   logic [LVL_W-1:0]  level;
   logic              full;
   logic              overflow;
   logic [CNT_W-1:0]  drop_cnt;

   fib_result_collector #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .N_W    (N_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .n         (n),
      .data      (data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_n     (out_n),
      .out_data  (out_data),
      .level     (level),
      .full      (full),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt),
      .clr_ovf   (clr_ovf)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] fib(input int k);
      logic [DATA_W-1:0] a, b, t;
      a = 1;
      b = 1;
      for (int i = 0; i < k; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // scoreboard: expected queue contents and counters
   logic [E_W-1:0] exp_q[$];
   bit             m_cap_vld = 1'b0;
   logic [N_W-1:0] m_cap_n = '0;
   bit             m_ovf = 1'b0;
   int             m_drop = 0;
   bit             m_pop, m_push;
   bit             chk_en = 1'b0;

   always @(posedge clk) begin
      if (!resetn) begin
         exp_q.delete();
         m_cap_vld = 1'b0;
         m_ovf     = 1'b0;
         m_drop    = 0;
      end else begin
         m_pop  = (exp_q.size() != 0) && out_ready;
         m_push = m_cap_vld && ((exp_q.size() < DEPTH) || m_pop);
         if (clr_ovf) begin
            m_ovf  = 1'b0;
            m_drop = 0;
         end else if (m_cap_vld && !m_push) begin
            m_ovf = 1'b1;
            if (m_drop < (1 << CNT_W) - 1) m_drop++;
         end
         if (m_pop) void'(exp_q.pop_front());
         if (m_push) exp_q.push_back({m_cap_n, data});
         m_cap_vld = start;
         m_cap_n   = n;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("out_valid", out_valid, exp_q.size() != 0);
         check("level", level, exp_q.size());
         check("full", full, exp_q.size() == DEPTH);
         check("overflow", overflow, m_ovf);
         check("drop_cnt", drop_cnt, m_drop);
         if (exp_q.size() != 0) begin
            check("out_n", out_n, exp_q[0][E_W-1:DATA_W]);
            check("out_data", out_data, exp_q[0][DATA_W-1:0]);
         end
      end
   end

   // driver: one call per cycle, inputs change on the falling edge
   bit             pend_vld = 1'b0;
   logic [N_W-1:0] pend_n = '0;

   task automatic step(input bit rn, input bit s, input logic [N_W-1:0] nn,
                       input bit rdy, input bit clr);
      @(negedge clk);
      data      = pend_vld ? fib(int'(pend_n)) : DATA_W'($urandom);
      pend_vld  = s;
      pend_n    = nn;
      resetn    = rn;
      start     = s;
      n         = nn;
      out_ready = rdy;
      clr_ovf   = clr;
   endtask

   task automatic idle(input bit rdy);
      step(1'b1, 1'b0, '0, rdy, 1'b0);
   endtask

   logic [N_W-1:0] fp_order[DEPTH];

   initial begin
      // reset state
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      chk_en = 1'b1;
      check("rst_valid", out_valid, 0);
      check("rst_level", level, 0);
      check("rst_ovf", overflow, 0);
      check("rst_drop", drop_cnt, 0);

      // single request, consumer always ready
      step(1'b1, 1'b1, 4'd5, 1'b1, 1'b0);
      idle(1'b1);
      check("single_lat_valid", out_valid, 0);
      idle(1'b1);
      check("single_valid", out_valid, 1);
      check("single_n", out_n, 5);
      check("single_data", out_data, 8);
      idle(1'b1);
      check("single_gone", out_valid, 0);
      check("single_level", level, 0);

      // burst of DEPTH with a stalled consumer, then drain
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, N_W'(i), 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      check("burst_level", level, 8);
      check("burst_full", full, 1);
      check("burst_ovf", overflow, 0);
      for (int k = 0; k < DEPTH; k++) begin
         idle(1'b1);
         check("burst_drain_n", out_n, k);
      end
      idle(1'b1);
      check("burst_empty", out_valid, 0);

      // overflow: ten requests into eight slots
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, N_W'(i), 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      check("ovf_level", level, 8);
      check("ovf_flag", overflow, 1);
      check("ovf_drop", drop_cnt, 2);

      // clear coinciding with a drop, then a fresh drop
      step(1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0, 1'b1);
      idle(1'b0);
      check("clr_ovf_flag", overflow, 0);
      check("clr_drop", drop_cnt, 0);
      step(1'b1, 1'b1, 4'd4, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      check("redrop_cnt", drop_cnt, 1);
      check("redrop_flag", overflow, 1);

      // full with a pop in the push cycle: no drop, new entry last
      step(1'b1, 1'b1, 4'd9, 1'b0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b1, 1'b0);
      idle(1'b0);
      check("fp_level", level, 8);
      check("fp_full", full, 1);
      check("fp_drop", drop_cnt, 1);
      for (int k = 0; k < DEPTH - 1; k++) fp_order[k] = N_W'(k + 1);
      fp_order[DEPTH-1] = 4'd9;
      for (int k = 0; k < DEPTH; k++) begin
         idle(1'b1);
         check("fp_drain_valid", out_valid, 1);
         check("fp_drain_n", out_n, fp_order[k]);
      end
      check("fp_last_data", out_data, 55);
      idle(1'b1);
      check("fp_empty", out_valid, 0);

      // reset mid-burst discards queued and in-flight results
      step(1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 4'd2, 1'b0, 1'b0);
      step(1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      idle(1'b1);
      check("mrst_valid", out_valid, 0);
      check("mrst_level", level, 0);
      for (int k = 0; k < 3; k++) begin
         idle(1'b1);
         check("mrst_no_ghost", out_valid, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
